n_bit_serial_subtractor: RTL and testbench



---
 rtl/n_bit_serial_subtractor.sv | 119 +++++++++++
 tb/tb_n_bit_serial_subtractor.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/n_bit_serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per clock, LSB first,
// through a single full-subtractor cell with a registered borrow.
// Start/done handshake. The results and status hold until the next
// operation completes.
module n_bit_serial_subtractor #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         borrow_out,
    output logic         zero
);

    localparam int            CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [N-1:0]  a_sh_q;
    logic [N-1:0]  b_sh_q;
    logic [N-1:0]  res_q;
    logic          brw_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;
    logic [N-1:0]  diff_q;
    logic          borrow_q;
    logic          zero_q;

    logic          a_bit;
    logic          b_bit;
    logic          d_bit_d;
    logic          bout_d;
    logic [N-1:0]  res_d;

    // Full-subtractor cell on the operand LSBs; the new difference bit enters the result from the MSB end
    always_comb begin
        a_bit   = a_sh_q[0];
        b_bit   = b_sh_q[0];
        d_bit_d = a_bit ^ b_bit ^ brw_q;
        bout_d  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & brw_q);
        res_d   = {d_bit_d, res_q[N-1:1]};
    end

    // Control FSM with the operand/result shift registers and the registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            brw_q    <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        brw_q   <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    res_q  <= res_d;
                    brw_q  <= bout_d;
                    if (cnt_q == LAST) begin
                        // Last bit: publish the result; the counter stops here rather than wrapping
                        diff_q   <= res_d;
                        borrow_q <= bout_d;
                        zero_q   <= (res_d == '0);
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign zero       = zero_q;

endmodule

// File: tb/tb_n_bit_serial_subtractor.sv
// Self-checking bench for n_bit_serial_subtractor (N = 8): directed and random
// operations against an arithmetic reference model, a held-start handshake
// pattern, and an asynchronous reset during RUN.
module tb_n_bit_serial_subtractor;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         borrow_out;
    logic         zero;

    int tests;
    int fails;

    // Reference model: the result currently presented on the outputs
    logic [N-1:0] m_diff;
    logic         m_borrow;
    logic         m_zero;

    n_bit_serial_subtractor #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .zero       (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Plain-arithmetic reference: (a - b) mod 2^N, borrow iff a < b
    task automatic model(input logic [N-1:0] av, input logic [N-1:0] bv);
        int d;
        d = int'(av) - int'(bv);
        if (d < 0) d = d + (1 << N);
        m_diff   = d[N-1:0];
        m_borrow = (av < bv);
        m_zero   = (d == 0);
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".diff"}, 32'(diff), 32'(m_diff));
        chk({tag, ".borrow"}, 32'(borrow_out), 32'(m_borrow));
        chk({tag, ".zero"}, 32'(zero), 32'(m_zero));
    endtask

    // One full operation with a single-cycle start pulse, checking latency, busy width and result hold
    task automatic run_op(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv);
        int lat;
        int busy_cnt;
        logic [N-1:0] held;
        held  = m_diff;
        a     = av;
        b     = bv;
        start = 1'b1;
        tick();
        start    = 1'b0;
        a        = N'($urandom);
        b        = N'($urandom);
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 20) begin
            chk({tag, ".hold"}, 32'(diff), 32'(held));
            chk({tag, ".excl"}, 32'(busy & done), 32'(0));
            if (busy) busy_cnt++;
            tick();
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(N));
        chk({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(N));
        chk({tag, ".busy_at_done"}, 32'(busy), 32'(0));
        model(av, bv);
        chk_outputs(tag);
        tick();
        chk({tag, ".done_pulse"}, 32'(done), 32'(0));
        chk({tag, ".idle_busy"}, 32'(busy), 32'(0));
    endtask

    logic [N-1:0] op_a [0:29];
    logic [N-1:0] op_b [0:29];

    initial begin
        int phase;
        int acc;
        logic [N-1:0] ra;
        logic [N-1:0] rb;

        tests    = 0;
        fails    = 0;
        m_diff   = '0;
        m_borrow = 1'b0;
        m_zero   = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        rst_n    = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("reset.busy", 32'(busy), 32'(0));
        chk("reset.done", 32'(done), 32'(0));
        chk_outputs("reset");
        tick();
        tick();
        rst_n = 1'b1;

        // Directed cases
        run_op("d5A_23", 8'h5A, 8'h23);
        run_op("d10_20", 8'h10, 8'h20);
        run_op("d00_01", 8'h00, 8'h01);
        run_op("dFF_00", 8'hFF, 8'h00);
        run_op("d7F_7F", 8'h7F, 8'h7F);
        run_op("d00_00", 8'h00, 8'h00);

        // Random operations
        for (int i = 0; i < 20; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            if (i == 5) rb = ra;
            run_op("rand", ra, rb);
        end

        // start held high, operands changing every cycle: accepts at edges 0, 10, 20
        start = 1'b1;
        acc   = 0;
        for (int k = 0; k < 30; k++) begin
            op_a[k] = N'($urandom);
            op_b[k] = N'($urandom);
            a = op_a[k];
            b = op_b[k];
            if (k == 29) start = 1'b0;
            tick();
            phase = k % (N + 2);
            chk("held.busy", 32'(busy), 32'(phase < N));
            chk("held.done", 32'(done), 32'(phase == N));
            if (phase == N) begin
                model(op_a[acc], op_b[acc]);
                acc = acc + N + 2;
            end
            chk_outputs("held");
        end

        // Reset during RUN
        run_op("pre_abort", 8'h5A, 8'h23);
        a     = 8'h12;
        b     = 8'h34;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("abort.busy_before", 32'(busy), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        m_diff   = '0;
        m_borrow = 1'b0;
        m_zero   = 1'b0;
        chk("abort.busy", 32'(busy), 32'(0));
        chk("abort.done", 32'(done), 32'(0));
        chk_outputs("abort");
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("abort.no_done", 32'(done), 32'(0));
            chk("abort.no_busy", 32'(busy), 32'(0));
        end
        run_op("post_abort", 8'h80, 8'h01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time limit so the bench can never hang
    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
